nvram_upload: RTL and testbench

Read-side counterpart of the NVRAM download path: serves HPS `ioctl_upload` requests for the high-score/EEPROM image by reading the core's NVRAM dual-port RAM and presenting bytes on `ioctl_din`. Sits in the top level between `hps_io` and the game core. While an upload is in progress it holds the core in pause, so the image is a coherent snapshot. Also tracks whether NVRAM changed since the last complete save.

---
 rtl/nvram_upload.sv | 237 +++++++++++++++++++++++
 tb/tb_nvram_upload.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload.sv
`default_nettype none
// ============================================================================
//  Module   : nvram_upload
//  Brief    : Serves HPS ioctl_upload reads of the NVRAM image from the core's
//             NVRAM dual-port RAM. The core is held paused for the whole
//             upload so the image is a coherent snapshot.
//  Options  : NVRAM_DIRTY_EN - track NVRAM modification since the last
//             complete upload; when undefined, dirty is tied to 1.
//  Revision : 1.0 - initial release
// ============================================================================
module nvram_upload #(
  parameter int AW     = 9,   // NVRAM address width, image = 2^AW bytes
  parameter int INDEX  = 4,   // ioctl_index value selecting the NVRAM image
  parameter int SETTLE = 4    // cycles after pause_ack before serving (1..15)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  input  logic          nvram_wr,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          busy,
  output logic          dirty
);

  localparam logic [7:0] C_INDEX       = 8'(INDEX);
  localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE - 1);
  // READY waits this many cycles after leaving SETTLE before the first
  // read, so the first response has a fixed latency from READY entry.
  localparam logic [1:0] C_WARM_LOAD   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PAUSE  = 3'd1,
    S_SETTLE = 3'd2,
    S_READY  = 3'd3,
    S_FETCH  = 3'd4,
    S_LATCH  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  warm_q, warm_d;
  logic        pend_vld_q, pend_vld_d;
  logic [24:0] pend_addr_q, pend_addr_d;
  logic        req_oor_q, req_oor_d;
  logic [7:0]  din_q, din_d;
  logic        active_q, active_d;

`ifdef NVRAM_DIRTY_EN
  logic        req_first_q, req_first_d;
  logic        req_last_q, req_last_d;
  logic        first_hit_q, first_hit_d;
  logic        last_hit_q, last_hit_d;
  logic        dirty_q, dirty_d;
`endif

  // Request decode and RAM read port (combinational so ram_rd aligns with
  // the strobe cycle). A fresh strobe beats a pending entry: last address wins.
  logic        w_sel;
  logic [24:0] w_srv_addr;
  logic        w_srv_oor;
  logic        w_serve;
  logic        w_capture;

  assign w_sel      = ioctl_upload && (ioctl_index == C_INDEX);
  assign w_srv_addr = ioctl_rd ? ioctl_addr : pend_addr_q;
  assign w_srv_oor  = |w_srv_addr[24:AW];
  assign w_serve    = (state_q == S_READY) && w_sel && (warm_q == 2'd0) &&
                      (ioctl_rd || pend_vld_q);
  assign w_capture  = ioctl_rd && w_sel &&
                      ((state_q == S_PAUSE) || (state_q == S_SETTLE) ||
                       (state_q == S_FETCH) || (state_q == S_LATCH) ||
                       ((state_q == S_READY) && (warm_q != 2'd0)));

  assign ram_rd    = w_serve && !w_srv_oor;
  assign ram_addr  = ram_rd ? w_srv_addr[AW-1:0] : '0;
  assign ioctl_din = din_q;
  assign pause_req = active_q;
  assign busy      = active_q;

`ifdef NVRAM_DIRTY_EN
  assign dirty = dirty_q;
`else
  assign dirty = 1'b1;
  logic w_unused;
  assign w_unused = nvram_wr;
`endif

  // Next-state, pending slot, response data and dirty/coverage tracking.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    warm_d      = warm_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    req_oor_d   = req_oor_q;
    din_d       = din_q;
`ifdef NVRAM_DIRTY_EN
    req_first_d = req_first_q;
    req_last_d  = req_last_q;
    first_hit_d = first_hit_q;
    last_hit_d  = last_hit_q;
    dirty_d     = dirty_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_sel) begin
          state_d    = S_PAUSE;
          pend_vld_d = 1'b0;
`ifdef NVRAM_DIRTY_EN
          first_hit_d = 1'b0;
          last_hit_d  = 1'b0;
`endif
        end
      end
      S_PAUSE: begin
        if (pause_ack) begin
          state_d = S_SETTLE;
          cnt_d   = C_SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_READY;
          warm_d  = C_WARM_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READY: begin
        if (warm_q != 2'd0) begin
          warm_d = warm_q - 2'd1;
        end else if (w_serve) begin
          state_d    = S_FETCH;
          req_oor_d  = w_srv_oor;
          pend_vld_d = 1'b0;
`ifdef NVRAM_DIRTY_EN
          req_first_d = (w_srv_addr == 25'd0);
          req_last_d  = !w_srv_oor && (w_srv_addr[AW-1:0] == {AW{1'b1}});
`endif
        end
      end
      S_FETCH: begin
        // Out-of-range reads skip the RAM but keep the same latency.
        state_d = S_LATCH;
        din_d   = req_oor_q ? 8'hFF : ram_q;
`ifdef NVRAM_DIRTY_EN
        if (req_first_q) first_hit_d = 1'b1;
        if (req_last_q && first_hit_q) last_hit_d = 1'b1;
`endif
      end
      S_LATCH: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes that cannot be served right now park in the one-entry slot.
    if (w_capture) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = ioctl_addr;
    end

    // Losing the selection (upload end or index change) aborts the session.
    if ((state_q != S_IDLE) && !w_sel) begin
      state_d    = S_IDLE;
      pend_vld_d = 1'b0;
`ifdef NVRAM_DIRTY_EN
      first_hit_d = 1'b0;
      last_hit_d  = 1'b0;
      if (last_hit_q) dirty_d = 1'b0;
`endif
    end

`ifdef NVRAM_DIRTY_EN
    // A write on the clearing cycle keeps the image marked modified.
    if (nvram_wr) dirty_d = 1'b1;
`endif

    active_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      warm_q      <= 2'd0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 25'd0;
      req_oor_q   <= 1'b0;
      din_q       <= 8'd0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      req_oor_q   <= req_oor_d;
      din_q       <= din_d;
      active_q    <= active_d;
    end
  end

`ifdef NVRAM_DIRTY_EN
  // Coverage flags and dirty flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_first_q <= 1'b0;
      req_last_q  <= 1'b0;
      first_hit_q <= 1'b0;
      last_hit_q  <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      req_first_q <= req_first_d;
      req_last_q  <= req_last_d;
      first_hit_q <= first_hit_d;
      last_hit_q  <= last_hit_d;
      dirty_q     <= dirty_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nvram_upload.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nvram_upload
//  Brief    : Directed, scoreboard-based bench for nvram_upload (AW=9,
//             INDEX=4, SETTLE=4). Dirty expectations follow NVRAM_DIRTY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nvram_upload;

`ifdef NVRAM_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic [8:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        nvram_wr;
  logic        pause_req;
  logic        pause_ack;
  logic        busy;
  logic        dirty;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem [0:511];

  nvram_upload #(.AW(9), .INDEX(4), .SETTLE(4)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .ram_q       (ram_q),
    .nvram_wr    (nvram_wr),
    .pause_req   (pause_req),
    .pause_ack   (pause_ack),
    .busy        (busy),
    .dirty       (dirty)
  );

  always #5 clk_sys = ~clk_sys;

  // NVRAM model: registered read, data one cycle after ram_rd.
  always @(posedge clk_sys) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_dirty(input logic v);
    return DIRTY_EN ? v : 1'b1;
  endfunction

  // One READY-state read: strobe now, response two cycles later.
  task automatic do_read(input logic [24:0] a, input logic [7:0] e, input logic exp_rd);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    exp_q.push_back(e);
    #1;
    chk("ram_rd_at_strobe", ram_rd, exp_rd);
    if (exp_rd) chk("ram_addr_at_strobe", ram_addr, a[8:0]);
    step();
    ioctl_rd = 1'b0;
    step();
    chk("din_response", ioctl_din, exp_q.pop_front());
  endtask

  // Raise selection, ack 3 cycles after pause_req, return when READY serves.
  task automatic start_session();
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    pause_ack    = 1'b0;
    step();
    chk("pause_req_rise", pause_req, 1);
    chk("busy_rise", busy, 1);
    step();
    step();
    step();
    pause_ack = 1'b1;
    repeat (7) step();
  endtask

  task automatic end_session(input logic wr, input logic exp_d);
    ioctl_upload = 1'b0;
    nvram_wr     = wr;
    step();
    nvram_wr  = 1'b0;
    pause_ack = 1'b0;
    chk("pause_req_fall", pause_req, 0);
    chk("busy_fall", busy, 0);
    chk("dirty_after_end", dirty, exp_dirty(exp_d));
  endtask

  task automatic pulse_wr();
    nvram_wr = 1'b1;
    step();
    nvram_wr = 1'b0;
    chk("dirty_set_by_wr", dirty, 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 25'd0;
    nvram_wr     = 1'b0;
    pause_ack    = 1'b0;
    repeat (3) step();

    // Reset state.
    chk("rst_din", ioctl_din, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_pause_req", pause_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dirty", dirty, exp_dirty(1'b0));
    reset = 1'b0;
    step();

    // Session 1: full dump, out-of-range reads, dense strobes.
    pulse_wr();
    start_session();
    for (int i = 0; i < 512; i++) begin
      do_read(25'(i), 8'(i) ^ 8'hA5, 1'b1);
      chk("pause_held", pause_req, 1);
      step();
      step();
    end
    do_read(25'h200, 8'hFF, 1'b0);
    step();
    do_read(25'h1FFFFFF, 8'hFF, 1'b0);
    step();
    // Strobes in READY, FETCH and LATCH: the LATCH one overwrites FETCH's.
    ioctl_addr = 25'd10;
    ioctl_rd   = 1'b1;
    exp_q.push_back(8'd10 ^ 8'hA5);
    step();
    ioctl_addr = 25'd20;
    step();
    ioctl_addr = 25'd30;
    exp_q.push_back(8'd30 ^ 8'hA5);
    chk("dense_first_din", ioctl_din, exp_q.pop_front());
    step();
    ioctl_rd = 1'b0;
    #1;
    chk("dense_pending_rd", ram_rd, 1);
    chk("dense_pending_addr", ram_addr, 9'd30);
    step();
    step();
    chk("dense_last_wins_din", ioctl_din, exp_q.pop_front());
    step();
    end_session(1'b0, 1'b0);
    step();

    // Session 2: strobe during PAUSE, then a partial upload.
    pulse_wr();
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    pause_ack    = 1'b0;
    step();
    chk("s2_pause_req_rise", pause_req, 1);
    ioctl_addr = 25'd5;
    ioctl_rd   = 1'b1;
    exp_q.push_back(8'd5 ^ 8'hA5);
    step();
    ioctl_rd = 1'b0;
    step();
    pause_ack = 1'b1;
    repeat (6) step();
    chk("early_no_rd_yet", ram_rd, 0);
    step();
    chk("early_rd_issue", ram_rd, 1);
    chk("early_rd_addr", ram_addr, 9'd5);
    step();
    step();
    chk("early_din", ioctl_din, exp_q.pop_front());
    step();
    for (int i = 0; i <= 100; i++) begin
      do_read(25'(i), 8'(i) ^ 8'hA5, 1'b1);
      step();
    end
    end_session(1'b0, 1'b1);
    step();

    // Session 3: complete coverage but a write on the closing cycle.
    start_session();
    do_read(25'd0, 8'h00 ^ 8'hA5, 1'b1);
    step();
    do_read(25'd511, 8'hFF ^ 8'hA5, 1'b1);
    step();
    end_session(1'b1, 1'b1);
    step();

    // Session 4: reset in READY, then a fresh upload proceeds.
    start_session();
    do_read(25'd7, 8'd7 ^ 8'hA5, 1'b1);
    step();
    pulse_wr();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_pause_req", pause_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_din", ioctl_din, 0);
    chk("mid_rst_dirty", dirty, exp_dirty(1'b0));
    step();
    chk("post_rst_pause_req", pause_req, 1);
    repeat (7) step();
    do_read(25'd42, 8'd42 ^ 8'hA5, 1'b1);
    step();
    // Index change while uploading ends the session.
    ioctl_index = 8'd5;
    step();
    chk("index_change_pause_req", pause_req, 0);
    chk("index_change_busy", busy, 0);
    chk("index_change_dirty", dirty, exp_dirty(1'b0));
    ioctl_upload = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
